// File: rtl/cpu_ctrl_if.sv
// Control bundle between the CPU control FSM (master) and the datapath (slave).
// Decoded opcode, branch and resume flags come in; datapath enables go out.
interface cpu_ctrl_if;
  logic [2:0] instr_type;
  logic       branch_cond;
  logic       resume;
  logic       PC_enable;
  logic       PC_load;
  logic       IR_enable;
  logic       R_enable;
  logic       ALU_Bus_enable;
  logic       reg_read;
  logic       mem_we;
  logic       halted;
  logic       illegal_op;
  logic [3:0] state_out;

  modport master (
    input  instr_type, branch_cond, resume,
    output PC_enable, PC_load, IR_enable, R_enable, ALU_Bus_enable,
           reg_read, mem_we, halted, illegal_op, state_out
  );

  modport slave (
    output instr_type, branch_cond, resume,
    input  PC_enable, PC_load, IR_enable, R_enable, ALU_Bus_enable,
           reg_read, mem_we, halted, illegal_op, state_out
  );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control FSM: fetch/decode/execute sequencing with
// configurable memory wait cycles, halt/resume and illegal-opcode stepping.
module cpu_ctrl_fsm #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  cpu_ctrl_if.master bus
);

  localparam int unsigned WW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [WW-1:0] FETCH_LAST = WW'(MEM_WAIT);
  localparam logic [WW-1:0] WAIT_LAST  = WW'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);
  localparam logic [WW-1:0] WCNT_ONE   = WW'(1);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC      = 4'd2,
    S_STORE     = 4'd3,
    S_LOAD_ADDR = 4'd4,
    S_LOAD_WAIT = 4'd5,
    S_LOAD_WB   = 4'd6,
    S_BRANCH    = 4'd7,
    S_ADVANCE   = 4'd8,
    S_HALT      = 4'd9
  } state_e;

  state_e        state_q;
  logic [WW-1:0] wcnt_q;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; reset is synchronous and wins over all arcs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      wcnt_q  <= '0;
    end else begin
      wcnt_q <= '0;
      case (state_q)
        S_FETCH: begin
          if (wcnt_q == FETCH_LAST) state_q <= S_DECODE;
          else                      wcnt_q  <= wcnt_q + WCNT_ONE;
        end
        S_DECODE: begin
          unique case (bus.instr_type)
            3'b000:  state_q <= S_EXEC;
            3'b001:  state_q <= S_STORE;
            3'b010:  state_q <= S_LOAD_ADDR;
            3'b011:  state_q <= S_BRANCH;
            3'b100:  state_q <= S_HALT;
            default: state_q <= S_ADVANCE;
          endcase
        end
        S_LOAD_ADDR: state_q <= (MEM_WAIT > 0) ? S_LOAD_WAIT : S_LOAD_WB;
        S_LOAD_WAIT: begin
          if (wcnt_q == WAIT_LAST) state_q <= S_LOAD_WB;
          else                     wcnt_q  <= wcnt_q + WCNT_ONE;
        end
        S_HALT: begin
          // The exit step reuses the ADVANCE code; wcnt=1 marks it as a
          // resume rather than an illegal opcode.
          if (bus.resume) begin
            state_q <= S_ADVANCE;
            wcnt_q  <= WCNT_ONE;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // NOTE: every output gets a default before the case, so no latch can form.
  always_comb begin
    bus.PC_enable      = 1'b0;
    bus.PC_load        = 1'b0;
    bus.IR_enable      = 1'b0;
    bus.R_enable       = 1'b0;
    bus.ALU_Bus_enable = 1'b0;
    bus.reg_read       = 1'b0;
    bus.mem_we         = 1'b0;
    bus.halted         = 1'b0;
    bus.illegal_op     = 1'b0;
    bus.state_out      = state_q;
    case (state_q)
      S_FETCH: begin
        bus.ALU_Bus_enable = 1'b1;
        bus.IR_enable      = (wcnt_q == FETCH_LAST);
      end
      S_DECODE: bus.ALU_Bus_enable = 1'b1;
      S_EXEC: begin
        bus.PC_enable      = 1'b1;
        bus.R_enable       = 1'b1;
        bus.ALU_Bus_enable = 1'b1;
      end
      S_STORE: begin
        bus.PC_enable = 1'b1;
        bus.reg_read  = 1'b1;
        bus.mem_we    = 1'b1;
      end
      S_LOAD_ADDR: begin
        bus.PC_enable = 1'b1;
        bus.reg_read  = 1'b1;
      end
      S_LOAD_WAIT: bus.reg_read = 1'b1;
      S_LOAD_WB: begin
        bus.R_enable       = 1'b1;
        bus.reg_read       = 1'b1;
        bus.ALU_Bus_enable = 1'b1;
      end
      S_BRANCH: begin
        // Taken and not-taken are mutually exclusive PC actions.
        bus.ALU_Bus_enable = 1'b1;
        bus.PC_load        = bus.branch_cond;
        bus.PC_enable      = ~bus.branch_cond;
      end
      S_ADVANCE: begin
        bus.PC_enable  = 1'b1;
        bus.illegal_op = (wcnt_q == '0);
      end
      S_HALT: bus.halted = 1'b1;
      default: ;
    endcase
  end

endmodule
